// File: rtl/event_scheduler_gen.sv
// Window event scheduler: per-row todo FIFOs feeding ordered window reads.
// Optional macro ES_DROP_OOB_EN drops centres whose row/col leave their field.
module event_scheduler_gen #(
  parameter int DATA_WIDTH       = 4,
  parameter int HALF_WINDOW_SIZE = 1,
  parameter int COL_BITS         = 8,
  parameter int ADDR_W           = 16,
  parameter int TODO_FIFO_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_event_value,
  input  logic [ADDR_W-1:0]     in_event_addr,
  input  logic                  in_event_valid,
  output logic                  ready_for_new_event,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  st_wr_en,
  output logic [ADDR_W-1:0]     st_wr_addr,
  output logic [DATA_WIDTH-1:0] st_wr_value,
  input  logic                  st_wr_done,
  output logic                  st_rd_req,
  output logic [ADDR_W-1:0]     st_rd_addr,
  input  logic [(2*HALF_WINDOW_SIZE+1)*(2*HALF_WINDOW_SIZE+1)*DATA_WIDTH-1:0] st_rd_window,
  input  logic                  st_rd_valid,
  input  logic                  window_req,
  output logic [(2*HALF_WINDOW_SIZE+1)*(2*HALF_WINDOW_SIZE+1)*DATA_WIDTH-1:0] out_window_value,
  output logic [ADDR_W-1:0]     out_window_addr,
  output logic                  out_window_valid,
  output logic                  fifo_overflow
);

  localparam int W  = 2*HALF_WINDOW_SIZE + 1;
  localparam int H  = HALF_WINDOW_SIZE;
  localparam int PW = $clog2(TODO_FIFO_DEPTH);
  localparam int KW = $clog2(W + 1);
  localparam int RB = ADDR_W - COL_BITS;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PW:0]       ptr_t;

  localparam addr_t ORIGIN = addr_t'((H << COL_BITS) + H);

  typedef enum logic [2:0] {
    IDLE, PUSH, SEL, FSEL, READ, OUT, WWR
  } state_t;

  state_t                state;
  addr_t                 last_addr;
  addr_t                 ev_addr;
  addr_t                 avail;
  addr_t                 cand_q;
  addr_t                 cand;
  addr_t                 d_new;
  logic [DATA_WIDTH-1:0] ev_value;
  logic [KW-1:0]         k_cnt;
  logic [KW-1:0]         k_start;
  logic                  flushing;
  logic                  any;
  logic                  push_cyc;

  addr_t      mem [W][TODO_FIFO_DEPTH];
  ptr_t       wptr [W];
  ptr_t       rptr [W];
  addr_t      head [W];
  addr_t      push_addr [W];
  logic [W-1:0] empty;
  logic [W-1:0] full;
  logic [W-1:0] push_ok;
  logic [W-1:0] push_we;
  logic [W-1:0] pop;

  assign ready_for_new_event = (state == IDLE);
  assign push_cyc = (state == PUSH) && (k_cnt < KW'(W));

  always_comb begin
    for (int r = 0; r < W; r++) begin
      head[r]  = mem[r][rptr[r][PW-1:0]];
      empty[r] = (wptr[r] == rptr[r]);
      full[r]  = (wptr[r][PW] != rptr[r][PW]) &&
                 (wptr[r][PW-1:0] == rptr[r][PW-1:0]);
    end
  end

`ifdef ES_DROP_OOB_EN
  logic [RB+1:0]       row_f [W];
  logic [COL_BITS+1:0] col_f;

  always_comb begin
    col_f = {2'b00, ev_addr[COL_BITS-1:0]}
          + (COL_BITS+2)'(k_cnt) - (COL_BITS+2)'(H);
    for (int r = 0; r < W; r++) begin
      row_f[r] = {2'b00, ev_addr[ADDR_W-1:COL_BITS]}
               + (RB+2)'(r) - (RB+2)'(H);
      push_addr[r] = {row_f[r][RB-1:0], col_f[COL_BITS-1:0]};
      push_ok[r]   = (row_f[r][RB+1:RB] == 2'b00) &&
                     (col_f[COL_BITS+1:COL_BITS] == 2'b00);
    end
  end
`else
  always_comb begin
    for (int r = 0; r < W; r++) begin
      push_addr[r] = ev_addr + addr_t'(r << COL_BITS)
                   + addr_t'(k_cnt) - ORIGIN;
      push_ok[r]   = 1'b1;
    end
  end
`endif

  always_comb begin
    for (int r = 0; r < W; r++) begin
      push_we[r] = push_cyc && push_ok[r] && !full[r];
      pop[r]     = (state == OUT) && window_req &&
                   !empty[r] && (head[r] == cand_q);
    end
  end

  // Smallest pending centre across all row heads.
  always_comb begin
    any  = 1'b0;
    cand = '0;
    for (int r = 0; r < W; r++) begin
      if (!empty[r] && (!any || head[r] < cand)) begin
        cand = head[r];
        any  = 1'b1;
      end
    end
  end

  // Columns already covered by the previous event are skipped.
  always_comb begin
    d_new = in_event_addr - last_addr;
    if (d_new >= addr_t'(W))
      k_start = '0;
    else if (d_new == '0)
      k_start = KW'(W);
    else
      k_start = KW'(W) - d_new[KW-1:0];
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < W; r++)
      if (push_we[r])
        mem[r][wptr[r][PW-1:0]] <= push_addr[r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      last_addr        <= '0;
      ev_addr          <= '0;
      ev_value         <= '0;
      avail            <= '0;
      cand_q           <= '0;
      k_cnt            <= '0;
      flushing         <= 1'b0;
      flush_done       <= 1'b0;
      st_wr_en         <= 1'b0;
      st_wr_addr       <= '0;
      st_wr_value      <= '0;
      st_rd_req        <= 1'b0;
      st_rd_addr       <= '0;
      out_window_value <= '0;
      out_window_addr  <= '0;
      out_window_valid <= 1'b0;
      fifo_overflow    <= 1'b0;
      for (int r = 0; r < W; r++) begin
        wptr[r] <= '0;
        rptr[r] <= '0;
      end
    end else begin
      st_wr_en   <= 1'b0;
      st_rd_req  <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_event_valid) begin
            ev_addr   <= in_event_addr;
            ev_value  <= in_event_value;
            avail     <= in_event_addr - ORIGIN;
            last_addr <= in_event_addr;
            k_cnt     <= k_start;
            flushing  <= 1'b0;
            state     <= PUSH;
          end else if (flush) begin
            flushing <= 1'b1;
            state    <= FSEL;
          end
        end
        PUSH: begin
          if (push_cyc) begin
            for (int r = 0; r < W; r++) begin
              if (push_ok[r] && full[r])
                fifo_overflow <= 1'b1;
              if (push_we[r])
                wptr[r] <= wptr[r] + 1'b1;
            end
            k_cnt <= k_cnt + 1'b1;
            if (k_cnt == KW'(W - 1))
              state <= SEL;
          end else begin
            state <= SEL;
          end
        end
        SEL, FSEL: begin
          if (any && (state == FSEL || cand < avail)) begin
            st_rd_req  <= 1'b1;
            st_rd_addr <= cand;
            cand_q     <= cand;
            state      <= READ;
          end else if (state == SEL) begin
            st_wr_en    <= 1'b1;
            st_wr_addr  <= ev_addr;
            st_wr_value <= ev_value;
            state       <= WWR;
          end else begin
            flush_done <= 1'b1;
            last_addr  <= '0;
            state      <= IDLE;
          end
        end
        READ: begin
          if (st_rd_valid) begin
            out_window_value <= st_rd_window;
            out_window_addr  <= cand_q;
            out_window_valid <= 1'b1;
            state            <= OUT;
          end
        end
        OUT: begin
          if (window_req) begin
            out_window_valid <= 1'b0;
            for (int r = 0; r < W; r++)
              if (pop[r])
                rptr[r] <= rptr[r] + 1'b1;
            state <= flushing ? FSEL : SEL;
          end
        end
        WWR: begin
          if (st_wr_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_event_scheduler_gen.sv
// Bench for event_scheduler_gen: sorted-set reference model, random events.
// Second instance with depth 4 exercises the overflow flag.
module tb_event_scheduler_gen;

  localparam int DW = 4;
  localparam int H  = 1;
  localparam int W  = 3;
  localparam int AW = 16;
  localparam int WW = W*W*DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_event_value;
  logic [AW-1:0] in_event_addr;
  logic          in_event_valid;
  logic          ready_for_new_event;
  logic          flush;
  logic          flush_done;
  logic          st_wr_en;
  logic [AW-1:0] st_wr_addr;
  logic [DW-1:0] st_wr_value;
  logic          st_wr_done;
  logic          st_rd_req;
  logic [AW-1:0] st_rd_addr;
  logic [WW-1:0] st_rd_window;
  logic          st_rd_valid;
  logic          window_req;
  logic [WW-1:0] out_window_value;
  logic [AW-1:0] out_window_addr;
  logic          out_window_valid;
  logic          fifo_overflow;

  logic          s_valid, s_ready, s_flush, s_flush_done;
  logic          s_wr_en, s_wr_done, s_rd_req, s_rd_valid;
  logic [AW-1:0] s_wr_addr, s_rd_addr, s_win_addr;
  logic [DW-1:0] s_wr_value;
  logic [WW-1:0] s_rd_window, s_win_value;
  logic          s_window_req, s_win_valid, s_overflow;

  always #5 clk = ~clk;

  event_scheduler_gen u_dut (
    .clk(clk), .rst(rst),
    .in_event_value(in_event_value), .in_event_addr(in_event_addr),
    .in_event_valid(in_event_valid),
    .ready_for_new_event(ready_for_new_event),
    .flush(flush), .flush_done(flush_done),
    .st_wr_en(st_wr_en), .st_wr_addr(st_wr_addr),
    .st_wr_value(st_wr_value), .st_wr_done(st_wr_done),
    .st_rd_req(st_rd_req), .st_rd_addr(st_rd_addr),
    .st_rd_window(st_rd_window), .st_rd_valid(st_rd_valid),
    .window_req(window_req), .out_window_value(out_window_value),
    .out_window_addr(out_window_addr),
    .out_window_valid(out_window_valid),
    .fifo_overflow(fifo_overflow)
  );

  event_scheduler_gen #(.TODO_FIFO_DEPTH(4)) u_small (
    .clk(clk), .rst(rst),
    .in_event_value(in_event_value), .in_event_addr(in_event_addr),
    .in_event_valid(s_valid), .ready_for_new_event(s_ready),
    .flush(s_flush), .flush_done(s_flush_done),
    .st_wr_en(s_wr_en), .st_wr_addr(s_wr_addr),
    .st_wr_value(s_wr_value), .st_wr_done(s_wr_done),
    .st_rd_req(s_rd_req), .st_rd_addr(s_rd_addr),
    .st_rd_window(s_rd_window), .st_rd_valid(s_rd_valid),
    .window_req(s_window_req), .out_window_value(s_win_value),
    .out_window_addr(s_win_addr), .out_window_valid(s_win_valid),
    .fifo_overflow(s_overflow)
  );

  int vectors = 0;
  int miscompares = 0;
  int win_cnt;
  int unsigned pend[$];
  int unsigned exp_q[$];
  logic [AW-1:0] last_m;

  function automatic logic [WW-1:0] win_of(input logic [AW-1:0] a);
    return {a[3:0] ^ 4'h9, a, a ^ 16'h5A3C};
  endfunction

  // Storage stub: every request is answered on the following cycle.
  initial begin
    st_rd_valid = 0; st_wr_done = 0; st_rd_window = '0;
    s_rd_valid = 0; s_wr_done = 0; s_rd_window = '0;
    forever begin
      @(posedge clk); #1;
      st_rd_valid  = st_rd_req;
      st_rd_window = win_of(st_rd_addr);
      st_wr_done   = st_wr_en;
      s_rd_valid   = s_rd_req;
      s_rd_window  = win_of(s_rd_addr);
      s_wr_done    = s_wr_en;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic insert(input int unsigned c);
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i] == c) return;
      if (pend[i] > c) begin
        pend.insert(i, c);
        return;
      end
    end
    pend.push_back(c);
  endtask

  task automatic model_event(input logic [AW-1:0] a);
    int unsigned d, av;
    int row, col;
    d  = (int'(a) - int'(last_m)) & 32'hFFFF;
    av = (int'(a) - (H << 8) - H) & 32'hFFFF;
    for (int k = 0; k < W; k++) begin
      if (!(d >= W || (d != 0 && k >= W - d))) continue;
      for (int r = 0; r < W; r++) begin
`ifdef ES_DROP_OOB_EN
        row = int'(a[15:8]) + r - H;
        col = int'(a[7:0]) + k - H;
        if (row >= 0 && row < 256 && col >= 0 && col < 256)
          insert((row << 8) | col);
`else
        row = r - H;
        col = k - H;
        insert((int'(a) + (row << 8) + col) & 32'hFFFF);
`endif
      end
    end
    while (pend.size() != 0 && pend[0] < av)
      exp_q.push_back(pend.pop_front());
    last_m = a;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready_for_new_event && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ready_for_new_event, 1'b1);
  endtask

  task automatic serve(input bit is_flush, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wv, input int stall);
    int n = 0;
    int held = 0;
    bit done = 0;
    win_cnt = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (out_window_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window", out_window_valid, 1'b0);
          window_req = 1'b1;
        end else begin
          chk("win_addr", out_window_addr, exp_q[0]);
          chk("win_value", out_window_value, win_of(exp_q[0]));
          if (held < stall) begin
            window_req = 1'b0;
            held++;
          end else begin
            window_req = ($urandom_range(0, 3) != 0);
            if (window_req) begin
              void'(exp_q.pop_front());
              win_cnt++;
            end
          end
        end
      end else begin
        window_req = 1'($urandom_range(0, 1));
      end
      if (st_wr_en) begin
        if (is_flush) chk("flush_wr_en", st_wr_en, 1'b0);
        else begin
          chk("wr_addr", st_wr_addr, wa);
          chk("wr_value", st_wr_value, wv);
        end
        chk("windows_left", exp_q.size(), 0);
        done = 1;
      end
      if (flush_done) begin
        if (!is_flush) chk("event_flush_done", flush_done, 1'b0);
        chk("windows_left", exp_q.size(), 0);
        done = 1;
      end
    end
    chk("op_timeout", done, 1'b1);
    chk("overflow_clear", fifo_overflow, 1'b0);
    window_req = 1'b0;
  endtask

  task automatic apply_event(input logic [AW-1:0] a, input logic [DW-1:0] v,
                             input int stall);
    wait_ready("ready_event");
    exp_q.delete();
    model_event(a);
    in_event_addr  = a;
    in_event_value = v;
    in_event_valid = 1'b1;
    @(negedge clk);
    in_event_valid = 1'b0;
    serve(1'b0, a, v, stall);
  endtask

  task automatic do_flush(input int stall);
    wait_ready("ready_flush");
    exp_q.delete();
    foreach (pend[i]) exp_q.push_back(pend[i]);
    pend.delete();
    last_m = '0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    serve(1'b1, '0, '0, stall);
  endtask

  task automatic small_event(input logic [AW-1:0] a);
    int n = 0;
    while (!s_ready && n < 500) begin @(negedge clk); n++; end
    chk("small_ready", s_ready, 1'b1);
    in_event_addr = a;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (!s_ready && n < 500) begin @(negedge clk); n++; end
    chk("small_done", s_ready, 1'b1);
  endtask

  initial begin
    int row, col;
    rst = 1; in_event_valid = 0; in_event_addr = '0; in_event_value = '0;
    flush = 0; window_req = 0; last_m = '0;
    s_valid = 0; s_flush = 0; s_window_req = 1;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_for_new_event, 1'b1);
    chk("rst_valid", out_window_valid, 1'b0);
    chk("rst_wr_en", st_wr_en, 1'b0);
    chk("rst_rd_req", st_rd_req, 1'b0);
    chk("rst_overflow", fifo_overflow, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", ready_for_new_event, 1'b1);

    apply_event(16'h0505, 4'd3, 0);
    chk("first_event_windows", win_cnt, 0);
    apply_event(16'h0506, 4'd7, 0);
    chk("second_event_windows", win_cnt, 1);
    do_flush(10);
    chk("flush_windows", win_cnt, 11);

    row = 16'h10; col = 5;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0 || row > 16'hF0) begin
        do_flush(0);
        row = $urandom_range(1, 16'h40);
        col = $urandom_range(1, 4);
      end else begin
        apply_event(16'((row << 8) | col), 4'($urandom),
                    ($urandom_range(0, 7) == 0) ? 3 : 0);
        col += $urandom_range(0, 3);
        if (col > 16'h10) begin
          row += $urandom_range(1, 2);
          col = $urandom_range(1, 4);
        end
      end
    end
    do_flush(0);

`ifdef ES_DROP_OOB_EN
    apply_event(16'h0001, 4'd5, 0);
    chk("oob_windows", win_cnt, 2);
    do_flush(0);
    chk("oob_flush_windows", win_cnt, 0);
`endif

    chk("small_overflow_init", s_overflow, 1'b0);
    small_event(16'h0505);
    chk("small_overflow_first", s_overflow, 1'b0);
    small_event(16'h0508);
    chk("small_overflow_set", s_overflow, 1'b1);
    repeat (20) @(negedge clk);
    chk("small_overflow_sticky", s_overflow, 1'b1);
    chk("main_overflow_clear", fifo_overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
